// File: rtl/pipe_pkg.sv
// Shared types for the flow-controlled pipeline stage register:
// skid-buffer state encoding and occupancy width.
package pipe_pkg;

  localparam int OCC_W = 2;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  function automatic logic [OCC_W-1:0] occ_of(input state_e s);
    case (s)
      ST_EMPTY: return 2'd0;
      ST_ONE:   return 2'd1;
      ST_TWO:   return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One {valid, ctrl, data} holding register. Clearing zeroes the payload so
// control bits can never leak out of an empty slot.
module pipe_slot #(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [CTRL_W-1:0] i_ctrl,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DATA_W-1:0] r_data;

  // Priority: reset, then clear, then load; otherwise hold.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ctrl  <= i_ctrl;
      r_data  <= i_data;
    end else begin
      r_valid <= r_valid;
      r_ctrl  <= r_ctrl;
      r_data  <= r_data;
    end
  end

  assign o_valid = r_valid;
  assign o_ctrl  = r_ctrl;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with flush. SKID=1 gives a
// two-entry skid buffer with registered in_ready; SKID=0 a single entry.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 2,
  parameter int DATA_W = 69,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy
);

  if (SKID != 0) begin : g_skid
    logic              w_main_valid, w_skid_valid;
    logic [CTRL_W-1:0] w_main_ctrl, w_skid_ctrl, w_main_ctrl_in;
    logic [DATA_W-1:0] w_main_data, w_skid_data, w_main_data_in;
    logic              w_accept, w_pop;
    logic              w_main_load, w_main_clr, w_skid_load, w_skid_clr, w_from_skid;
    state_e            w_state;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = w_main_valid & out_ready;

    always_comb begin
      if (w_skid_valid)      w_state = ST_TWO;
      else if (w_main_valid) w_state = ST_ONE;
      else                   w_state = ST_EMPTY;
    end

    // Flush clears both slots; it wins over any load inside pipe_slot.
    always_comb begin
      w_main_load = 1'b0;
      w_main_clr  = flush;
      w_skid_load = 1'b0;
      w_skid_clr  = flush;
      w_from_skid = 1'b0;
      case (w_state)
        ST_EMPTY: w_main_load = w_accept;
        ST_ONE: begin
          if (w_pop) begin
            w_main_load = w_accept;
            w_main_clr  = flush | ~w_accept;
          end else begin
            w_skid_load = w_accept;
          end
        end
        ST_TWO: begin
          if (w_pop) begin
            w_main_load = 1'b1;
            w_from_skid = 1'b1;
            w_skid_clr  = 1'b1;
          end else begin
            w_main_load = 1'b0;
          end
        end
        default: w_main_load = 1'b0;
      endcase
    end

    assign w_main_ctrl_in = w_from_skid ? w_skid_ctrl : in_ctrl;
    assign w_main_data_in = w_from_skid ? w_skid_data : in_data;

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk(clk), .reset(reset), .i_clear(w_main_clr), .i_load(w_main_load),
      .i_ctrl(w_main_ctrl_in), .i_data(w_main_data_in),
      .o_valid(w_main_valid), .o_ctrl(w_main_ctrl), .o_data(w_main_data)
    );

    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
      .clk(clk), .reset(reset), .i_clear(w_skid_clr), .i_load(w_skid_load),
      .i_ctrl(in_ctrl), .i_data(in_data),
      .o_valid(w_skid_valid), .o_ctrl(w_skid_ctrl), .o_data(w_skid_data)
    );

    assign in_ready  = ~w_skid_valid;
    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_ctrl;
    assign out_data  = w_main_data;
    assign occupancy = occ_of(w_state);
  end else begin : g_single
    logic              w_valid;
    logic [CTRL_W-1:0] w_ctrl;
    logic [DATA_W-1:0] w_data;
    logic              w_accept, w_pop;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = w_valid & out_ready;

    // Accept and pop together simply reload the slot, so no bubble appears.
    pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk(clk), .reset(reset), .i_clear(flush | (w_pop & ~w_accept)), .i_load(w_accept),
      .i_ctrl(in_ctrl), .i_data(in_data),
      .o_valid(w_valid), .o_ctrl(w_ctrl), .o_data(w_data)
    );

    assign in_ready  = ~w_valid | out_ready;
    assign out_valid = w_valid;
    assign out_ctrl  = w_ctrl;
    assign out_data  = w_data;
    assign occupancy = {1'b0, w_valid};
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: SKID=1 instance for stream/back-pressure/flush/reset,
// SKID=0 instance for combinational-ready stall behaviour.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_ctrl, out_ctrl, occupancy;
  logic [68:0] in_data, out_data;

  logic        z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
  logic [1:0]  z_in_ctrl, z_out_ctrl, z_occupancy;
  logic [68:0] z_in_data, z_out_data;

  int total = 0;
  int bad   = 0;

  localparam logic [68:0] D0 = 69'h1_DEAD_BEEF_12;
  localparam logic [68:0] DA = 69'h0A_AAAA_AAAA_0001;
  localparam logic [68:0] DB = 69'h0B_BBBB_BBBB_0002;
  localparam logic [68:0] DC = 69'h0C_CCCC_CCCC_0003;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .SKID(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_stage_reg #(.CTRL_W(2), .DATA_W(69), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(z_flush),
    .in_valid(z_in_valid), .in_ready(z_in_ready), .in_ctrl(z_in_ctrl), .in_data(z_in_data),
    .out_valid(z_out_valid), .out_ready(z_out_ready), .out_ctrl(z_out_ctrl), .out_data(z_out_data),
    .occupancy(z_occupancy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b1 == 1'b0, 2'b00, 2'd0, 1'b1}) begin
      bad++;
      $display("FAIL reset_flags got %b want %b", {out_valid, out_ctrl, occupancy, in_ready}, 6'b0_00_00_1);
    end
    total++;
    if (out_data !== 69'd0) begin
      bad++;
      $display("FAIL reset_data got %h want 0", out_data);
    end
    total++;
    if ({z_out_valid, z_occupancy, z_in_ready} !== 4'b0_00_1) begin
      bad++;
      $display("FAIL reset_skid0 got %b want 0001", {z_out_valid, z_occupancy, z_in_ready});
    end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_valid = 1'b1; in_ctrl = 2'b11; in_data = D0;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_ctrl, occupancy} !== 5'b1_11_01 || out_data !== D0) begin
      bad++;
      $display("FAIL stream_out got %b/%h want 11101/%h", {out_valid, out_ctrl, occupancy}, out_data, D0);
    end
    step();
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== 6'b0_00_00_1) begin
      bad++;
      $display("FAIL stream_drain got %b want 000001", {out_valid, out_ctrl, occupancy, in_ready});
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 2'b01; in_data = DA;
    step();
    in_ctrl = 2'b10; in_data = DB;
    step();
    in_valid = 1'b0;
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== 6'b1_01_10_0 || out_data !== DA) begin
      bad++;
      $display("FAIL bp_full got %b/%h want 101100/%h", {out_valid, out_ctrl, occupancy, in_ready}, out_data, DA);
    end
    step();
    total++;
    if ({out_valid, out_ctrl, occupancy} !== 5'b1_01_10 || out_data !== DA) begin
      bad++;
      $display("FAIL bp_hold got %b/%h want 10110/%h", {out_valid, out_ctrl, occupancy}, out_data, DA);
    end
    out_ready = 1'b1;
    step();
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== 6'b1_10_01_1 || out_data !== DB) begin
      bad++;
      $display("FAIL bp_second got %b/%h want 110011/%h", {out_valid, out_ctrl, occupancy, in_ready}, out_data, DB);
    end
    step();
    total++;
    if ({out_valid, out_ctrl, occupancy} !== 5'b0_00_00) begin
      bad++;
      $display("FAIL bp_empty got %b want 00000", {out_valid, out_ctrl, occupancy});
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] c;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      c = 2'(i);
      in_valid = 1'b1; in_ctrl = c; in_data = 69'(i);
      step();
      total++;
      if ({out_valid, out_ctrl, occupancy, in_ready} !== {1'b1, c, 2'd1, 1'b1} || out_data !== 69'(i)) begin
        bad++;
        $display("FAIL b2b_beat%0d got %b/%0d want %b/%0d", i, {out_valid, out_ctrl, occupancy, in_ready},
                 out_data, {1'b1, c, 2'd1, 1'b1}, i);
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if ({out_valid, occupancy} !== 3'b0_00) begin
      bad++;
      $display("FAIL b2b_end got %b want 000", {out_valid, occupancy});
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 2'b01; in_data = DA;
    step();
    in_ctrl = 2'b10; in_data = DB;
    step();
    flush = 1'b1; in_ctrl = 2'b11; in_data = DC;
    step();
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== 6'b0_00_00_1 || out_data !== 69'd0) begin
      bad++;
      $display("FAIL flush_two got %b/%h want 000001/0", {out_valid, out_ctrl, occupancy, in_ready}, out_data);
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++;
    if ({out_valid, occupancy} !== 3'b0_00) begin
      bad++;
      $display("FAIL flush_drop got %b want 000", {out_valid, occupancy});
    end
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 2'b01; in_data = DA;
    step();
    flush = 1'b1; in_ctrl = 2'b11; in_data = DC;
    step();
    flush = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== 6'b0_00_00_1) begin
      bad++;
      $display("FAIL flush_ready_drop got %b want 000001", {out_valid, out_ctrl, occupancy, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 2'b01; in_data = DA;
    step();
    in_ctrl = 2'b10; in_data = DB;
    step();
    total++;
    if (occupancy !== 2'd2) begin
      bad++;
      $display("FAIL rmid_pre got %0d want 2", occupancy);
    end
    reset = 1'b1; in_ctrl = 2'b11; in_data = DC;
    step();
    reset = 1'b0; in_valid = 1'b0;
    total++;
    if ({out_valid, out_ctrl, occupancy, in_ready} !== 6'b0_00_00_1 || out_data !== 69'd0) begin
      bad++;
      $display("FAIL rmid_post got %b/%h want 000001/0", {out_valid, out_ctrl, occupancy, in_ready}, out_data);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rmid_drop got %b want 0", out_valid);
    end
  endtask

  task automatic test_skid0_stall();
    z_out_ready = 1'b1;
    z_in_valid = 1'b1; z_in_ctrl = 2'b01; z_in_data = DA;
    step();
    total++;
    if ({z_out_valid, z_out_ctrl, z_occupancy} !== 5'b1_01_01 || z_out_data !== DA) begin
      bad++;
      $display("FAIL s0_first got %b/%h want 10101/%h", {z_out_valid, z_out_ctrl, z_occupancy}, z_out_data, DA);
    end
    z_out_ready = 1'b0; z_in_ctrl = 2'b10; z_in_data = DB;
    #1;
    total++;
    if (z_in_ready !== 1'b0) begin
      bad++;
      $display("FAIL s0_ready_low got %b want 0", z_in_ready);
    end
    step();
    total++;
    if ({z_out_valid, z_out_ctrl, z_occupancy} !== 5'b1_01_01 || z_out_data !== DA) begin
      bad++;
      $display("FAIL s0_hold got %b/%h want 10101/%h", {z_out_valid, z_out_ctrl, z_occupancy}, z_out_data, DA);
    end
    z_out_ready = 1'b1;
    #1;
    total++;
    if (z_in_ready !== 1'b1) begin
      bad++;
      $display("FAIL s0_ready_high got %b want 1", z_in_ready);
    end
    step();
    total++;
    if ({z_out_valid, z_out_ctrl, z_occupancy} !== 5'b1_10_01 || z_out_data !== DB) begin
      bad++;
      $display("FAIL s0_replace got %b/%h want 11001/%h", {z_out_valid, z_out_ctrl, z_occupancy}, z_out_data, DB);
    end
    z_in_ctrl = 2'b11; z_in_data = DC;
    step();
    total++;
    if ({z_out_valid, z_out_ctrl} !== 3'b1_11 || z_out_data !== DC) begin
      bad++;
      $display("FAIL s0_third got %b/%h want 111/%h", {z_out_valid, z_out_ctrl}, z_out_data, DC);
    end
    z_in_valid = 1'b0;
    step();
    total++;
    if ({z_out_valid, z_out_ctrl, z_occupancy, z_in_ready} !== 6'b0_00_00_1) begin
      bad++;
      $display("FAIL s0_empty got %b want 000001", {z_out_valid, z_out_ctrl, z_occupancy, z_in_ready});
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ctrl = 2'b00; in_data = 69'd0; out_ready = 1'b0;
    z_flush = 1'b0; z_in_valid = 1'b0; z_in_ctrl = 2'b00; z_in_data = 69'd0; z_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_skid0_stall();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
